// File: rtl/cacheline_pkg.sv
// Shared line/beat geometry and adaptor state type for the cache datapath and
// the memory-side cacheline adaptor.
package cacheline_pkg;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BEATS   = LINE_W / BURST_W;
    localparam int unsigned OFS_W   = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W   = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } cla_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one whole-line fill or writeback request from the cache into a burst of
// BEATS narrow beats on the physical-memory port; all outputs registered.
module cacheline_adaptor
    import cacheline_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ca_read,
    input  logic               ca_write,
    input  logic [ADDR_W-1:0]  ca_addr,
    input  logic [LINE_W-1:0]  ca_wdata,
    output logic [LINE_W-1:0]  ca_rdata,
    output logic               ca_resp,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BURST_W-1:0] mem_wdata,
    input  logic [BURST_W-1:0] mem_rdata,
    input  logic               mem_resp
);

    cla_state_t         r_state;
    cla_state_t         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last;
    logic [LINE_W-1:0]  r_wline;
    logic [LINE_W-1:0]  r_rdata;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_line_addr;
    logic [BURST_W-1:0] r_wdata;
    logic               r_resp;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               w_unused_ofs;

    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_last       = (r_cnt == CNT_W'(BEATS - 1));
    assign w_line_addr  = {ca_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
    // Byte offset within the line is intentionally discarded.
    assign w_unused_ofs = ^ca_addr[OFS_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; writeback wins when both requests are raised together.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (ca_write) begin
                    w_next_state = WRITE;
                end else if (ca_read) begin
                    w_next_state = READ;
                end
            end
            READ, WRITE: begin
                if (mem_resp && w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered outputs are derived from the state being entered, so they line
    // up with the state register; beat data moves only on a mem_resp strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_wline     <= '0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_resp      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_resp      <= (w_next_state == DONE);
            r_mem_read  <= (w_next_state == READ);
            r_mem_write <= (w_next_state == WRITE);
            unique case (r_state)
                IDLE: begin
                    if (ca_write) begin
                        r_wline <= ca_wdata;
                        r_wdata <= ca_wdata[BURST_W-1:0];
                        r_addr  <= w_line_addr;
                        r_cnt   <= '0;
                    end else if (ca_read) begin
                        r_addr  <= w_line_addr;
                        r_cnt   <= '0;
                    end
                end
                READ: begin
                    if (mem_resp) begin
                        r_rdata[r_cnt*BURST_W +: BURST_W] <= mem_rdata;
                        r_cnt                              <= w_cnt_inc;
                    end
                end
                WRITE: begin
                    if (mem_resp) begin
                        r_wdata <= r_wline[w_cnt_inc*BURST_W +: BURST_W];
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ca_rdata  = r_rdata;
    assign ca_resp   = r_resp;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: transaction tasks carry the expected
// per-cycle outputs, a negedge process compares them against the DUT.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic         ca_read;
    logic         ca_write;
    logic [31:0]  ca_addr;
    logic [255:0] ca_wdata;
    logic [255:0] ca_rdata;
    logic         ca_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    // expectations for the current cycle window
    logic         e_read;
    logic         e_write;
    logic         e_resp;
    logic [31:0]  e_addr;
    logic [63:0]  e_wdata;
    logic [255:0] e_rdata;

    int n_vec;
    int n_err;
    int n_resp;
    logic [31:0] last_addr;
    logic [63:0] wq[$];

    localparam logic [63:0] D0 = 64'hD0D0_0000_1111_0000;
    localparam logic [63:0] D1 = 64'hD1D1_0000_2222_0001;
    localparam logic [63:0] D2 = 64'hD2D2_0000_3333_0002;
    localparam logic [63:0] D3 = 64'hD3D3_0000_4444_0003;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .ca_read   (ca_read),
        .ca_write  (ca_write),
        .ca_addr   (ca_addr),
        .ca_wdata  (ca_wdata),
        .ca_rdata  (ca_rdata),
        .ca_resp   (ca_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle compare of the DUT against the expectation window
    always @(negedge clk) begin
        chk("mem_read", 256'(mem_read), 256'(e_read));
        chk("mem_write", 256'(mem_write), 256'(e_write));
        chk("ca_resp", 256'(ca_resp), 256'(e_resp));
        chk("ca_rdata", ca_rdata, e_rdata);
        if (e_read || e_write) chk("mem_addr", 256'(mem_addr), 256'(e_addr));
        if (e_write) chk("mem_wdata", 256'(mem_wdata), 256'(e_wdata));
        if (ca_resp) n_resp++;
        if (mem_read || mem_write) last_addr = mem_addr;
        if (mem_write && mem_resp) wq.push_back(mem_wdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_ca_resp", 256'(ca_resp), 256'(0));
        chk("rst_mem_read", 256'(mem_read), 256'(0));
        chk("rst_mem_write", 256'(mem_write), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr), 256'(0));
        chk("rst_mem_wdata", 256'(mem_wdata), 256'(0));
        chk("rst_ca_rdata", ca_rdata, 256'(0));
        e_read = 1'b0; e_write = 1'b0; e_resp = 1'b0; e_rdata = '0;
        ca_read = 1'b0; ca_write = 1'b0; mem_resp = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Fill: pattern bit i is mem_resp in burst cycle i; request held while fewer
    // than drop_at beats arrived; reset asserted right after beat rst_at if >= 0.
    task automatic fill(input logic [31:0] addr, input logic [255:0] line,
                        input logic [15:0] pat, input int plen, input int drop_at,
                        input bit hold_done, input int rst_at);
        int k;
        k = 0;
        ca_read = 1'b1; ca_write = 1'b0; ca_addr = addr;
        mem_resp = 1'b0; mem_rdata = {$urandom, $urandom};
        tick();
        e_read = 1'b1; e_write = 1'b0; e_resp = 1'b0;
        e_addr = {addr[31:5], 5'b0};
        for (int i = 0; i < plen && k < 4; i++) begin
            if (k >= drop_at) ca_read = 1'b0;
            ca_addr   = $urandom;
            mem_resp  = pat[i];
            mem_rdata = pat[i] ? line[k*64 +: 64] : {$urandom, $urandom};
            tick();
            if (pat[i]) begin
                e_rdata[k*64 +: 64] = line[k*64 +: 64];
                k++;
            end
            e_read = (k < 4);
            e_resp = (k == 4);
            if (rst_at >= 0 && k == rst_at) begin
                do_reset();
                return;
            end
        end
        mem_resp = 1'b0;
        ca_read  = hold_done;
        tick();
        e_read = 1'b0; e_resp = 1'b0;
    endtask

    task automatic wback(input logic [31:0] addr, input logic [255:0] line,
                         input logic [15:0] pat, input int plen,
                         input bit both, input bit hold_done);
        int k;
        k = 0;
        ca_write = 1'b1; ca_read = both; ca_addr = addr; ca_wdata = line;
        mem_resp = 1'b0;
        tick();
        e_write = 1'b1; e_read = 1'b0; e_resp = 1'b0;
        e_addr  = {addr[31:5], 5'b0};
        e_wdata = line[63:0];
        for (int i = 0; i < plen && k < 4; i++) begin
            ca_addr  = $urandom;
            ca_wdata = ~line;
            mem_resp = pat[i];
            mem_rdata = {$urandom, $urandom};
            tick();
            if (pat[i]) k++;
            e_write = (k < 4);
            e_resp  = (k == 4);
            if (k < 4) e_wdata = line[k*64 +: 64];
        end
        mem_resp = 1'b0;
        ca_write = hold_done;
        ca_read  = hold_done & both;
        tick();
        e_write = 1'b0; e_resp = 1'b0;
    endtask

    task automatic idle(input int n);
        ca_read = 1'b0; ca_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_resp  = (i % 2 == 0);
            mem_rdata = {$urandom, $urandom};
            tick();
        end
        mem_resp = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [255:0] l1;
        logic [255:0] lw;
        int r0;
        n_vec = 0; n_err = 0; n_resp = 0; last_addr = '0;
        rst = 1'b0; ca_read = 1'b0; ca_write = 1'b0; ca_addr = '0; ca_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        e_read = 1'b0; e_write = 1'b0; e_resp = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        tick();
        tick();
        rst = 1'b1;
        chk("reset_rdata", ca_rdata, 256'(0));
        chk("reset_mem_addr", 256'(mem_addr), 256'(0));
        tick();

        // basic fill, consecutive beats
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        r0 = n_resp;
        fill(32'h0000_1234, l1, 16'h000F, 4, 99, 1'b0, -1);
        chk("fill_addr_literal", 256'(last_addr), 256'(32'h0000_1220));
        chk("fill_line_literal", ca_rdata,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("fill_resp_count", 256'(n_resp - r0), 256'(1));

        // basic writeback, beat order D0..D3
        lw = {D3, D2, D1, D0};
        wq.delete();
        r0 = n_resp;
        wback(32'h0000_2047, lw, 16'h000F, 4, 1'b0, 1'b0);
        chk("wb_beat_count", 256'(wq.size()), 256'(4));
        if (wq.size() >= 4) begin
            chk("wb_beat0", 256'(wq[0]), 256'(D0));
            chk("wb_beat1", 256'(wq[1]), 256'(D1));
            chk("wb_beat2", 256'(wq[2]), 256'(D2));
            chk("wb_beat3", 256'(wq[3]), 256'(D3));
        end
        chk("wb_resp_count", 256'(n_resp - r0), 256'(1));

        // gapped beats 1,0,0,1,1,0,1
        r0 = n_resp;
        fill(32'h8000_00E0, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 16'h0059, 7, 99, 1'b0, -1);
        chk("gap_resp_count", 256'(n_resp - r0), 256'(1));

        // both requests: writeback wins, gapped
        wback(32'h0000_3000, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, 16'h00D5, 8, 1'b1, 1'b0);

        // strobes while idle are ignored
        idle(6);

        // request dropped after beat 1 still completes
        r0 = n_resp;
        fill(32'h0000_4010, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 16'h000F, 4, 1, 1'b0, -1);
        chk("drop_resp_count", 256'(n_resp - r0), 256'(1));

        // reset after beat 2 abandons the burst
        fill(32'h0000_5000, {64'hE3, 64'hE2, 64'hE1, 64'hE0}, 16'h000F, 4, 99, 1'b0, 2);
        chk("abort_rdata", ca_rdata, 256'(0));

        // next fill restarts from beat 0
        fill(32'h0000_6020, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 16'h001B, 5, 99, 1'b0, -1);

        // back-to-back with requests held through DONE
        r0 = n_resp;
        wback(32'h0000_7000, {64'h73, 64'h72, 64'h71, 64'h70}, 16'h000F, 4, 1'b0, 1'b1);
        fill(32'h0000_8000, {64'h83, 64'h82, 64'h81, 64'h80}, 16'h000F, 4, 99, 1'b1, -1);
        idle(3);
        chk("b2b_resp_count", 256'(n_resp - r0), 256'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
